fc_par_stream: RTL and testbench

FC_PAR_STREAM -- requirements
Module: fc_par_stream

---
 rtl/fc_pkg.sv | 38 +++
 rtl/fc_par_stream_if.sv | 33 +++
 rtl/fc_mac_lane.sv | 58 +++++
 rtl/fc_par_stream.sv | 221 ++++++++++++++++++++++
 tb/tb_fc_par_stream.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared types and helpers for the fc_par_stream block.
//   fc_state_e : controller state encoding (WLOAD, LOAD_X, COMPUTE, OUTPUT)
//   sat_hi/lo  : signed saturation bounds for a given data width t
//   sat_clamp  : clamp a 64-bit signed value into the t-bit signed range
package fc_pkg;

  typedef enum logic [1:0] {
    ST_WLOAD   = 2'd0,
    ST_LOAD_X  = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_OUTPUT  = 2'd3
  } fc_state_e;

  // Largest value representable in a t-bit two's-complement word.
  function automatic logic signed [63:0] sat_hi(input int unsigned t);
    return (64'sd1 <<< (t - 32'd1)) - 64'sd1;
  endfunction

  // Smallest value representable in a t-bit two's-complement word.
  function automatic logic signed [63:0] sat_lo(input int unsigned t);
    return -(64'sd1 <<< (t - 32'd1));
  endfunction

  // Clamp into the t-bit signed range; callers keep the low t bits.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned t);
    logic signed [63:0] r;
    if (v > sat_hi(t)) begin
      r = sat_hi(t);
    end else if (v < sat_lo(t)) begin
      r = sat_lo(t);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/fc_par_stream_if.sv
// fc_par_stream_if: the three handshake channels of fc_par_stream plus the
// weight-reload request.
//   w_valid/w_ready/w_data                : weight stream, row-major
//   input_valid/input_ready/input_data    : x vector elements
//   output_valid/output_ready/output_data : y results, row order
//   reload_w                              : request a new weight load
// Modports: master = traffic source/sink (bench or upstream), slave = the block.
interface fc_par_stream_if #(
  parameter int T = 12
) ();

  logic                w_valid;
  logic                w_ready;
  logic signed [T-1:0] w_data;
  logic                input_valid;
  logic                input_ready;
  logic signed [T-1:0] input_data;
  logic                output_valid;
  logic                output_ready;
  logic signed [T-1:0] output_data;
  logic                reload_w;

  modport master (
    output w_valid, w_data, input_valid, input_data, output_ready, reload_w,
    input  w_ready, input_ready, output_valid, output_data
  );

  modport slave (
    input  w_valid, w_data, input_valid, input_data, output_ready, reload_w,
    output w_ready, input_ready, output_valid, output_data
  );

endinterface

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one multiply-accumulate lane.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator (takes priority over accumulation)
//   in_valid   : a/b carry a valid operand pair this cycle
//   a, b       : signed T-bit operands
//   acc        : saturated T-bit accumulator
// The product is registered (one cycle), then added into the accumulator
// on the following edge; both the product and the sum saturate to T bits.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int T = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  input  logic signed [T-1:0] a,
  input  logic signed [T-1:0] b,
  output logic signed [T-1:0] acc
);

  logic signed [2*T-1:0] prod_full_s;
  logic signed [63:0]    prod_sat_s;
  logic signed [63:0]    sum_sat_s;
  logic signed [T-1:0]   prod_r;
  logic                  prod_v_r;
  logic signed [T-1:0]   acc_r;

  // Full-width product and saturated product/sum.
  always_comb begin
    prod_full_s = (2*T)'(a) * (2*T)'(b);
    prod_sat_s  = sat_clamp(64'(prod_full_s), T);
    sum_sat_s   = sat_clamp(64'(acc_r) + 64'(prod_r), T);
  end

  // Product register and saturating accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_r   <= {T{1'b0}};
      prod_v_r <= 1'b0;
      acc_r    <= {T{1'b0}};
    end else begin
      prod_v_r <= in_valid;
      if (in_valid) begin
        prod_r <= prod_sat_s[T-1:0];
      end
      if (clear) begin
        acc_r <= {T{1'b0}};
      end else if (prod_v_r) begin
        acc_r <= sum_sat_s[T-1:0];
      end
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/fc_par_stream.sv
// fc_par_stream: streaming fully-connected layer y = W*x with P parallel lanes.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : fc_par_stream_if.slave (weights in, x elements in, y out, reload_w)
// Parameters: M rows, N columns, T signed data width, P lanes (M % P == 0).
// Optional build macro FC_PAR_STREAM_RELU_EN: clamp negative results to 0.
// Weights for row r live in lane bank r%P at address (r/P)*N + c. Each group
// of P rows is computed in N read cycles; the memory read and product stage
// add two cycles, so the first result of a group is presented N+3 cycles
// after COMPUTE is entered.
module fc_par_stream
  import fc_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4,
  parameter int T = 12,
  parameter int P = 2
) (
  input  logic            clk,
  input  logic            reset,
  fc_par_stream_if.slave  bus
);

  localparam int GROUPS = M / P;
  localparam int DEPTH  = GROUPS * N;
  localparam int AW     = (DEPTH > 1)  ? $clog2(DEPTH)  : 1;
  localparam int XW     = (N > 1)      ? $clog2(N)      : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int PW     = (P > 1)      ? $clog2(P)      : 1;
  localparam int CW     = $clog2(N + 3) + 1;

  if ((M % P) != 0) begin : g_bad_lane_count
    $error("fc_par_stream: M must be a multiple of P");
  end

  fc_state_e           state_r;
  logic [XW-1:0]       w_col_r;
  logic [PW-1:0]       w_bank_r;
  logic [GW-1:0]       w_grp_r;
  logic [XW-1:0]       x_cnt_r;
  logic [GW-1:0]       grp_r;
  logic [CW-1:0]       cyc_r;
  logic [PW-1:0]       out_lane_r;
  logic                out_valid_r;
  logic signed [T-1:0] out_data_r;

  logic signed [T-1:0] wmem [P][2**AW];
  logic signed [T-1:0] xmem [2**XW];
  logic signed [T-1:0] rd_q [P];
  logic signed [T-1:0] x_q;
  logic                rd_q_v_r;
  logic signed [T-1:0] acc_s [P];

  logic                w_ready_s;
  logic                input_ready_s;
  logic                reload_s;
  logic                w_fire_s;
  logic                x_fire_s;
  logic                o_fire_s;
  logic                rd_v_s;
  logic                clear_s;
  logic [AW-1:0]       w_addr_s;
  logic [AW-1:0]       rd_addr_s;
  logic [PW-1:0]       nxt_lane_s;

  // Result formatting: optional rectification of the saturated accumulator.
  function automatic logic signed [T-1:0] out_val(input logic signed [T-1:0] a);
`ifdef FC_PAR_STREAM_RELU_EN
    return a[T-1] ? {T{1'b0}} : a;
`else
    return a;
`endif
  endfunction

  // A reload request only counts before any element of the vector is taken,
  // and it blocks the element offered in the same cycle.
  assign reload_s      = (state_r == ST_LOAD_X) && (x_cnt_r == XW'(0)) && bus.reload_w;
  assign w_ready_s     = (state_r == ST_WLOAD) && !reset;
  assign input_ready_s = (state_r == ST_LOAD_X) && !reload_s && !reset;
  assign w_fire_s      = bus.w_valid && w_ready_s;
  assign x_fire_s      = bus.input_valid && input_ready_s;
  assign o_fire_s      = out_valid_r && bus.output_ready;
  assign rd_v_s        = (state_r == ST_COMPUTE) && (cyc_r < CW'(N));
  assign clear_s       = (state_r == ST_COMPUTE) && (cyc_r == CW'(0));
  assign w_addr_s      = AW'(w_grp_r) * AW'(N) + AW'(w_col_r);
  assign rd_addr_s     = AW'(grp_r) * AW'(N) + AW'(cyc_r);
  assign nxt_lane_s    = out_lane_r + PW'(1);

  assign bus.w_ready      = w_ready_s;
  assign bus.input_ready  = input_ready_s;
  assign bus.output_valid = out_valid_r;
  assign bus.output_data  = out_data_r;

  // Weight and x storage with registered reads (contents undefined after reset).
  always_ff @(posedge clk) begin
    if (w_fire_s) begin
      wmem[w_bank_r][w_addr_s] <= bus.w_data;
    end
    if (x_fire_s) begin
      xmem[x_cnt_r] <= bus.input_data;
    end
    for (int p = 0; p < P; p++) begin
      rd_q[p] <= wmem[p][rd_addr_s];
    end
    x_q <= xmem[XW'(cyc_r)];
  end

  // Valid flag travelling alongside the registered memory read.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q_v_r <= 1'b0;
    end else begin
      rd_q_v_r <= rd_v_s;
    end
  end

  for (genvar p = 0; p < P; p++) begin : g_lane
    fc_mac_lane #(.T(T)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear_s),
      .in_valid (rd_q_v_r),
      .a        (rd_q[p]),
      .b        (x_q),
      .acc      (acc_s[p])
    );
  end

  // Controller: state, counters and the registered result channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_WLOAD;
      w_col_r     <= XW'(0);
      w_bank_r    <= PW'(0);
      w_grp_r     <= GW'(0);
      x_cnt_r     <= XW'(0);
      grp_r       <= GW'(0);
      cyc_r       <= CW'(0);
      out_lane_r  <= PW'(0);
      out_valid_r <= 1'b0;
      out_data_r  <= {T{1'b0}};
    end else begin
      case (state_r)
        ST_WLOAD: begin
          if (w_fire_s) begin
            if (w_col_r == XW'(N - 1)) begin
              w_col_r <= XW'(0);
              if (w_bank_r == PW'(P - 1)) begin
                w_bank_r <= PW'(0);
                if (w_grp_r == GW'(GROUPS - 1)) begin
                  w_grp_r <= GW'(0);
                  x_cnt_r <= XW'(0);
                  state_r <= ST_LOAD_X;
                end else begin
                  w_grp_r <= w_grp_r + GW'(1);
                end
              end else begin
                w_bank_r <= w_bank_r + PW'(1);
              end
            end else begin
              w_col_r <= w_col_r + XW'(1);
            end
          end
        end
        ST_LOAD_X: begin
          if (reload_s) begin
            w_col_r  <= XW'(0);
            w_bank_r <= PW'(0);
            w_grp_r  <= GW'(0);
            state_r  <= ST_WLOAD;
          end else if (x_fire_s) begin
            if (x_cnt_r == XW'(N - 1)) begin
              x_cnt_r <= XW'(0);
              grp_r   <= GW'(0);
              cyc_r   <= CW'(0);
              state_r <= ST_COMPUTE;
            end else begin
              x_cnt_r <= x_cnt_r + XW'(1);
            end
          end
        end
        ST_COMPUTE: begin
          // The last product lands in the accumulators during cycle N+2.
          if (cyc_r == CW'(N + 2)) begin
            cyc_r       <= CW'(0);
            out_lane_r  <= PW'(0);
            out_valid_r <= 1'b1;
            out_data_r  <= out_val(acc_s[0]);
            state_r     <= ST_OUTPUT;
          end else begin
            cyc_r <= cyc_r + CW'(1);
          end
        end
        ST_OUTPUT: begin
          if (o_fire_s) begin
            if (out_lane_r == PW'(P - 1)) begin
              out_valid_r <= 1'b0;
              out_lane_r  <= PW'(0);
              cyc_r       <= CW'(0);
              if (grp_r == GW'(GROUPS - 1)) begin
                grp_r   <= GW'(0);
                x_cnt_r <= XW'(0);
                state_r <= ST_LOAD_X;
              end else begin
                grp_r   <= grp_r + GW'(1);
                state_r <= ST_COMPUTE;
              end
            end else begin
              out_lane_r <= nxt_lane_s;
              out_data_r <= out_val(acc_s[nxt_lane_s]);
            end
          end
        end
        default: begin
          state_r <= ST_WLOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_par_stream.sv
// tb_fc_par_stream: self-checking bench for fc_par_stream (M=4,N=4,T=12,P=2).
// Expected results come from a row-by-row reference of y = W*x with saturated
// products and saturated running sums, honouring FC_PAR_STREAM_RELU_EN.
module tb_fc_par_stream;

  localparam int M = 4;
  localparam int N = 4;
  localparam int T = 12;
  localparam int P = 2;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   wm [M*N];
  int   xv [N];

  fc_par_stream_if #(.T(T)) bus ();

  fc_par_stream #(.M(M), .N(N), .T(T), .P(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int model_y(input int r);
    int acc;
    acc = 0;
    for (int c = 0; c < N; c++) acc = sat(acc + sat(wm[r*N+c] * xv[c]));
`ifdef FC_PAR_STREAM_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return acc;
  endfunction

  function automatic int rnd(input int a);
    return int'($urandom_range(0, 2*a)) - a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_w(input int v, output bit to);
    int k;
    k = 0;
    to = 1'b0;
    bus.w_valid = 1'b1;
    bus.w_data  = T'(v);
    while (!bus.w_ready && k < 50) begin tick(); k++; end
    if (bus.w_ready) tick(); else to = 1'b1;
    bus.w_valid = 1'b0;
  endtask

  task automatic send_x(input int v, input int gap, output bit to);
    int k;
    k = 0;
    to = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    bus.input_valid = 1'b1;
    bus.input_data  = T'(v);
    while (!bus.input_ready && k < 80) begin tick(); k++; end
    if (bus.input_ready) tick(); else to = 1'b1;
    bus.input_valid = 1'b0;
  endtask

  task automatic load_w(output int tos);
    bit to;
    tos = 0;
    for (int i = 0; i < M*N; i++) begin send_w(wm[i], to); tos += int'(to); end
  endtask

  task automatic load_x(input int maxgap, output int tos);
    bit to;
    tos = 0;
    for (int i = 0; i < N; i++) begin
      send_x(xv[i], int'($urandom_range(0, maxgap)), to);
      tos += int'(to);
    end
  endtask

  task automatic get_out(input bit rnd_ready, output int v, output bit to);
    int k;
    k = 0;
    v = 0;
    to = 1'b1;
    while (k < 300) begin
      bus.output_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.output_valid && bus.output_ready) begin
        v = int'(bus.output_data);
        to = 1'b0;
        tick();
        break;
      end
      tick();
      k++;
    end
  endtask

  task automatic pulse_reload();
    bus.reload_w = 1'b1;
    tick();
    bus.reload_w = 1'b0;
  endtask

  task automatic test_reset();
    bus.w_valid = 1'b0; bus.w_data = '0; bus.input_valid = 1'b0; bus.input_data = '0;
    bus.output_ready = 1'b0; bus.reload_w = 1'b0;
    reset = 1'b1;
    tick();
    vectors++;
    if (bus.w_ready !== 1'b0 || bus.input_ready !== 1'b0 || bus.output_valid !== 1'b0) begin
      $display("FAIL reset_cycle: w_ready=%b input_ready=%b output_valid=%b required 0 0 0",
               bus.w_ready, bus.input_ready, bus.output_valid);
      miscompares++;
    end
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.w_ready !== 1'b1 || bus.input_ready !== 1'b0 || bus.output_valid !== 1'b0
        || bus.output_data !== 12'sd0) begin
      $display("FAIL reset_release: w_ready=%b input_ready=%b output_valid=%b data=%0d required 1 0 0 0",
               bus.w_ready, bus.input_ready, bus.output_valid, bus.output_data);
      miscompares++;
    end
  endtask

  task automatic test_identity();
    int tos, k, v, exp;
    bit to;
    for (int i = 0; i < M*N; i++) wm[i] = ((i / N) == (i % N)) ? 1 : 0;
    load_w(tos);
    xv[0] = 5; xv[1] = -3; xv[2] = 7; xv[3] = 2;
    load_x(0, tos);
    vectors++;
    if (tos != 0 || bus.input_ready !== 1'b0) begin
      $display("FAIL identity_load: timeouts=%0d input_ready=%b required 0 0", tos, bus.input_ready);
      miscompares++;
    end
    k = 0;
    while (!bus.output_valid && k < 50) begin tick(); k++; end
    vectors++;
    if (k != N + 3) begin
      $display("FAIL identity_latency: output_valid after %0d cycles, required %0d", k, N + 3);
      miscompares++;
    end
    for (int r = 0; r < M; r++) begin
      get_out(1'b0, v, to);
      exp = model_y(r);
      vectors++;
      if (to || v !== exp) begin
        $display("FAIL identity y[%0d]: got %0d (timeout=%b) required %0d", r, v, to, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_prod_sat();
    int tos, v, exp;
    bit to;
    bus.reload_w = 1'b1;
    bus.input_valid = 1'b1;
    bus.input_data = 12'sd99;
    #1;
    vectors++;
    if (bus.input_ready !== 1'b0) begin
      $display("FAIL reload_priority: input_ready=%b required 0", bus.input_ready);
      miscompares++;
    end
    tick();
    bus.reload_w = 1'b0;
    bus.input_valid = 1'b0;
    #1;
    vectors++;
    if (bus.w_ready !== 1'b1) begin
      $display("FAIL reload_enter: w_ready=%b required 1", bus.w_ready);
      miscompares++;
    end
    for (int i = 0; i < M*N; i++) wm[i] = 0;
    wm[0] = 2047;
    wm[N] = -2048;
    load_w(tos);
    xv[0] = 2047;
    for (int c = 1; c < N; c++) xv[c] = rnd(2047);
    load_x(1, tos);
    for (int r = 0; r < M; r++) begin
      get_out(1'b0, v, to);
      exp = model_y(r);
      vectors++;
      if (to || v !== exp) begin
        $display("FAIL prod_sat y[%0d]: got %0d (timeout=%b) required %0d", r, v, to, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_acc_sat();
    int tos, v, exp;
    bit to;
    pulse_reload();
    for (int c = 0; c < N; c++) begin
      wm[c] = 1000;
      wm[N+c] = -1000;
      wm[2*N+c] = rnd(50);
      wm[3*N+c] = rnd(50);
      xv[c] = 1;
    end
    load_w(tos);
    load_x(0, tos);
    for (int r = 0; r < M; r++) begin
      get_out(1'b1, v, to);
      exp = model_y(r);
      vectors++;
      if (to || v !== exp) begin
        $display("FAIL acc_sat y[%0d]: got %0d (timeout=%b) required %0d", r, v, to, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_backpressure();
    int tos, k, v, exp, d0;
    bit to, held;
    pulse_reload();
    for (int i = 0; i < M*N; i++) wm[i] = rnd(60);
    for (int c = 0; c < N; c++) xv[c] = rnd(60);
    load_w(tos);
    bus.output_ready = 1'b0;
    load_x(2, tos);
    k = 0;
    while (!bus.output_valid && k < 50) begin tick(); k++; end
    d0 = int'(bus.output_data);
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (bus.output_valid !== 1'b1 || int'(bus.output_data) !== d0) begin
        $display("FAIL stall_hold cycle %0d: valid=%b data=%0d required 1 %0d",
                 i, bus.output_valid, bus.output_data, d0);
        miscompares++;
        held = 1'b0;
      end
    end
    for (int r = 0; r < M; r++) begin
      get_out(1'b0, v, to);
      exp = model_y(r);
      vectors++;
      if (to || v !== exp) begin
        $display("FAIL backpressure y[%0d]: got %0d (timeout=%b) required %0d", r, v, to, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_compute();
    int tos, k, v, exp;
    bit to;
    for (int c = 0; c < N; c++) xv[c] = rnd(100);
    bus.output_ready = 1'b1;
    load_x(0, tos);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.w_ready !== 1'b1) begin
      $display("FAIL abort_wready: w_ready=%b required 1", bus.w_ready);
      miscompares++;
    end
    k = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.output_valid) k++;
      tick();
    end
    vectors++;
    if (k != 0) begin
      $display("FAIL abort_no_output: output_valid seen %0d cycles, required 0", k);
      miscompares++;
    end
    for (int i = 0; i < M*N; i++) wm[i] = rnd(300);
    for (int c = 0; c < N; c++) xv[c] = rnd(300);
    load_w(tos);
    load_x(1, tos);
    for (int r = 0; r < M; r++) begin
      get_out(1'b0, v, to);
      exp = model_y(r);
      vectors++;
      if (to || v !== exp) begin
        $display("FAIL after_abort y[%0d]: got %0d (timeout=%b) required %0d", r, v, to, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int tos, v, exp;
    bit to;
    pulse_reload();
    for (int i = 0; i < M*N; i++) wm[i] = 1;
    load_w(tos);
    for (int c = 0; c < N; c++) xv[c] = 1;
    send_x(xv[0], 0, to);
    send_x(xv[1], 0, to);
    pulse_reload();
    vectors++;
    if (bus.w_ready !== 1'b0) begin
      $display("FAIL reload_ignored: w_ready=%b required 0", bus.w_ready);
      miscompares++;
    end
    send_x(xv[2], 0, to);
    send_x(xv[3], 0, to);
    for (int pass = 0; pass < 3; pass++) begin
      if (pass == 1) begin
        for (int c = 0; c < N; c++) xv[c] = 2;
        load_x(0, tos);
      end
      if (pass == 2) begin
        pulse_reload();
        for (int i = 0; i < M*N; i++) wm[i] = 2;
        load_w(tos);
        for (int c = 0; c < N; c++) xv[c] = 1;
        load_x(0, tos);
      end
      for (int r = 0; r < M; r++) begin
        get_out(1'b0, v, to);
        exp = (pass == 0) ? 4 : 8;
        vectors++;
        if (to || v !== exp || v !== model_y(r)) begin
          $display("FAIL back_to_back pass %0d y[%0d]: got %0d (timeout=%b) required %0d",
                   pass, r, v, to, exp);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_random();
    int tos, v, exp, range;
    bit to;
    for (int it = 0; it < 6; it++) begin
      range = (it % 2 == 1) ? 2047 : 60;
      if (it == 0 || $urandom_range(0, 1) == 1) begin
        pulse_reload();
        for (int i = 0; i < M*N; i++) wm[i] = rnd(range);
        load_w(tos);
      end
      for (int c = 0; c < N; c++) xv[c] = rnd(range);
      load_x(2, tos);
      for (int r = 0; r < M; r++) begin
        get_out(1'b1, v, to);
        exp = model_y(r);
        vectors++;
        if (to || v !== exp) begin
          $display("FAIL random it %0d y[%0d]: got %0d (timeout=%b) required %0d", it, r, v, to, exp);
          miscompares++;
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_identity();
    test_prod_sat();
    test_acc_sat();
    test_backpressure();
    test_reset_mid_compute();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
